mul_add: RTL and testbench

- Iterative shift-add multiply-accumulate: computes a_i*b_i + c_i unsigned, one multiplier bit per clock.
- Inverse companion to the team's iterative divider: feeding it quotient, divisor and remainder reconstructs the dividend.
- Same start/busy/done/valid handshake as the divider, so both sit behind the same arithmetic-unit sequencer.
- Full 2*WIDTH-bit result; no overflow is possible internally.

---
 rtl/mul_add_if.sv | 25 ++
 rtl/mul_add.sv | 94 +++++++++
 tb/tb_mul_add.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mul_add_if.sv
// rtl/mul_add_if.sv - start/busy/done/valid handshake and operand/result bundle for mul_add
interface mul_add_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] c_i;
  logic             busy_o;
  logic             done_o;
  logic             valid_o;
  logic             ovf_o;
  logic [WIDTH-1:0] prod_hi_o;
  logic [WIDTH-1:0] prod_lo_o;

  modport master (
    output start_i, a_i, b_i, c_i,
    input  busy_o, done_o, valid_o, ovf_o, prod_hi_o, prod_lo_o
  );

  modport slave (
    input  start_i, a_i, b_i, c_i,
    output busy_o, done_o, valid_o, ovf_o, prod_hi_o, prod_lo_o
  );
endinterface

// File: rtl/mul_add.sv
// rtl/mul_add.sv - iterative shift-add a*b+c, one multiplier bit per clock
// Optional MUL_ADD_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_add #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset_ni,
  mul_add_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [IW-1:0]      i;

  logic [2*WIDTH-1:0] mcand_next;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               finish;

  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;

  always_comb begin
    acc_next    = acc + (mplier[0] ? mcand : '0);
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
    finish      = (i == LAST);
`ifdef MUL_ADD_EARLY_EXIT_EN
    // No set bits left in the multiplier means acc_next is already the final sum.
    finish      = finish || (mplier_next == '0);
`else
`endif
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      i         <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start_i) begin
        // A restart discards any calculation in flight; the old result stays visible but invalid.
        state   <= RUN;
        mcand   <= {{WIDTH{1'b0}}, bus.a_i};
        mplier  <= bus.b_i;
        acc     <= {{WIDTH{1'b0}}, bus.c_i};
        i       <= '0;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
      end else if (state == RUN) begin
        if (finish) begin
          state     <= IDLE;
          prod_hi_q <= acc_next[2*WIDTH-1:WIDTH];
          prod_lo_q <= acc_next[WIDTH-1:0];
          ovf_q     <= (acc_next[2*WIDTH-1:WIDTH] != '0);
          done_q    <= 1'b1;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
        end else begin
          i      <= i + IW'(1);
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
        end
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.valid_o   = valid_q;
  assign bus.ovf_o     = ovf_q;
  assign bus.prod_hi_o = prod_hi_q;
  assign bus.prod_lo_o = prod_lo_q;
endmodule

// File: tb/tb_mul_add.sv
// tb/tb_mul_add.sv - randomized scoreboard bench for mul_add at WIDTH=8
module tb_mul_add;
  localparam int W = 8;

  logic clk;
  logic reset_ni;
  int   cyc;
  int   tests;
  int   fails;
  int   busy_run;

  mul_add_if #(.WIDTH(W)) bus ();

  mul_add #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           start_cyc;
    int           lat;
    int           busy_len;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [W-1:0] b);
    int lat;
    lat = W;
`ifdef MUL_ADD_EARLY_EXIT_EN
    lat = 1;
    for (int k = 0; k < W; k++)
      if (b[k]) lat = k + 1;
`else
`endif
    return lat;
  endfunction

  // Drives one start pulse; when push is set, the expected response goes onto the scoreboard.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input bit push, input int extra_busy);
    exp_t        e;
    logic [15:0] full;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.c_i     = c;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.a_i     = W'($urandom);
    bus.b_i     = W'($urandom);
    bus.c_i     = W'($urandom);
    if (push) begin
      full        = 16'(a) * 16'(b) + 16'(c);
      e.hi        = full[15:8];
      e.lo        = full[7:0];
      e.ovf       = (full > 16'd255);
      e.start_cyc = cyc;
      e.lat       = model_lat(b);
      e.busy_len  = model_lat(b) + extra_busy;
      sbq.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  task automatic wait_done(input bit chk_valid_low);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * W + 8 && !seen; k++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
      else if (chk_valid_low) check("valid_low_until_done", 64'(bus.valid_o), 64'd0);
    end
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  always @(negedge clk) begin
    if (bus.done_o) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1, expected no pending result");
      end else begin
        mon_e = sbq.pop_front();
        check("prod_hi", 64'(bus.prod_hi_o), 64'(mon_e.hi));
        check("prod_lo", 64'(bus.prod_lo_o), 64'(mon_e.lo));
        check("ovf", 64'(bus.ovf_o), 64'(mon_e.ovf));
        check("valid_at_done", 64'(bus.valid_o), 64'd1);
        check("busy_at_done", 64'(bus.busy_o), 64'd0);
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
        check("busy_cycles", 64'(busy_run), 64'(mon_e.busy_len));
      end
    end
    if (bus.busy_o) busy_run++;
    else busy_run = 0;
  end

  initial begin
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    int           gap;
    cyc = 0; tests = 0; fails = 0; busy_run = 0;
    bus.start_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.c_i = '0;
    reset_ni = 1'b1;
    #3 reset_ni = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    check("reset_done", 64'(bus.done_o), 64'd0);
    check("reset_valid", 64'(bus.valid_o), 64'd0);
    check("reset_ovf", 64'(bus.ovf_o), 64'd0);
    check("reset_prod", 64'({bus.prod_hi_o, bus.prod_lo_o}), 64'd0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;

    issue(8'd200, 8'd150, 8'd77, 1'b1, 0);   wait_done(1'b1);
    issue(8'd255, 8'd255, 8'd255, 1'b1, 0);  wait_done(1'b1);
    issue(8'd12, 8'd10, 8'd3, 1'b1, 0);      wait_done(1'b1);
    issue(8'd99, 8'd0, 8'd5, 1'b1, 0);       wait_done(1'b1);

    // Restart a few cycles into a calculation: only the second one completes.
    gap = (model_lat(8'd3) > 3) ? 3 : model_lat(8'd3) - 1;
    issue(8'd3, 8'd3, 8'd0, 1'b0, 0);
    repeat (gap - 1) @(negedge clk);
    issue(8'd7, 8'd9, 8'd1, 1'b1, gap);
    wait_done(1'b1);

    // Restart on the very edge the first calculation would finish.
    gap = model_lat(8'hA5);
    issue(8'h21, 8'hA5, 8'h09, 1'b0, 0);
    repeat (gap - 1) @(negedge clk);
    ph = last_hi;
    pl = last_lo;
    issue(8'h4C, 8'h90, 8'h11, 1'b1, gap);
    @(negedge clk);
    check("restart_hold_hi", 64'(bus.prod_hi_o), 64'(ph));
    check("restart_hold_lo", 64'(bus.prod_lo_o), 64'(pl));
    check("restart_valid_low", 64'(bus.valid_o), 64'd0);
    wait_done(1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb, rc;
      ra = W'($urandom);
      rb = (n % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      rc = W'($urandom);
      issue(ra, rb, rc, 1'b1, 0);
      wait_done(1'b1);
    end

    // Asynchronous reset in the middle of a calculation aborts it.
    issue(8'd200, 8'd150, 8'd77, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 reset_ni = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_valid", 64'(bus.valid_o), 64'd0);
    check("abort_ovf", 64'(bus.ovf_o), 64'd0);
    check("abort_prod", 64'({bus.prod_hi_o, bus.prod_lo_o}), 64'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_valid_low", 64'(bus.valid_o), 64'd0);
      check("idle_no_done", 64'(bus.done_o), 64'd0);
    end
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
